// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-side memory responder.
//   IO_BASE           : base byte address of the memory-mapped I/O window
//   io_reg_e          : I/O register select, word index within the window
//   ST_*              : bit positions inside the STATUS register
//   DROP_W            : width of the saturating dropped-byte counter
package dmem_resp_pkg;

  localparam logic [31:0] IO_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    IO_TXDATA = 2'd0,
    IO_STATUS = 2'd1,
    IO_TIMER  = 2'd2,
    IO_DROP   = 2'd3
  } io_reg_e;

  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_COUNT_LSB = 4;

  localparam int unsigned DROP_W = 16;

endpackage

// File: rtl/dmem_resp_if.sv
// Bus between the core data port / console sink and dmem_resp.
//   addr, wdata, memwrite : core load/store request
//   rdata                 : combinational load data
//   tx_data, tx_valid     : console byte stream from the TX FIFO head
//   tx_ready              : sink accepts the head byte at the clk edge
// master = core + sink side, slave = dmem_resp.
interface dmem_resp_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              memwrite;
  logic [DATA_W-1:0] rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output addr, wdata, memwrite, tx_ready,
    input  rdata, tx_data, tx_valid
  );

  modport slave (
    input  addr, wdata, memwrite, tx_ready,
    output rdata, tx_data, tx_valid
  );
endinterface

// File: rtl/dmem_resp_tx_fifo.sv
// Console TX byte FIFO, 2^FIFO_AW entries of 8 bits.
//   clk, rst : clock, asynchronous active-high reset
//   i_push   : push request; accepted when not full or popping this cycle
//   i_din    : byte to push
//   o_full   : FIFO holds 2^FIFO_AW bytes
//   i_pop    : sink ready; pops the head when the FIFO is non-empty
//   o_dout   : head byte (registered storage, no bypass)
//   o_valid  : FIFO non-empty
//   o_count  : number of bytes held
module dmem_tx_fifo #(
  parameter int unsigned FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [7:0]       i_din,
  output logic             o_full,
  input  logic             i_pop,
  output logic [7:0]       o_dout,
  output logic             o_valid,
  output logic [FIFO_AW:0] o_count
);
  localparam int unsigned DEPTH = 2 ** FIFO_AW;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_full = (r_count == (FIFO_AW+1)'(DEPTH));
  assign w_pop  = i_pop & (r_count != '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push = i_push & (~w_full | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      // Storage is cleared too so the head byte reads 0 out of reset.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = w_full;
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/dmem_resp.sv
// Data-side memory responder for the single-cycle MIPS core.
//   clk, rst : core clock, asynchronous active-high reset
//   bus      : dmem_resp_if slave port
//              addr/wdata/memwrite in, rdata out (combinational)
//              tx_data/tx_valid out, tx_ready in (console stream)
// addr[31]=0 selects the word RAM (index addr[RAM_AW+1:2], upper bits alias);
// addr[31]=1 selects I/O register addr[3:2]: TXDATA, STATUS, TIMER, DROP.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RAM_AW  = 8,
  parameter int unsigned FIFO_AW = 3
) (
  input logic        clk,
  input logic        rst,
  dmem_resp_if.slave bus
);
  logic              w_is_io;
  io_reg_e           w_sel;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_wr_ram;
  logic              w_wr_tx;
  logic              w_wr_timer;
  logic              w_wr_drop;
  logic              w_full;
  logic [FIFO_AW:0]  w_count;
  logic              w_drop;
  logic [DATA_W-1:0] w_status;
  logic              w_unused_addr;

  logic [DATA_W-1:0] r_ram [2 ** RAM_AW];
  logic [DATA_W-1:0] r_timer;
  logic [DROP_W-1:0] r_drop;

  assign w_is_io   = bus.addr[DATA_W-1];
  assign w_sel     = io_reg_e'(bus.addr[3:2]);
  assign w_ram_idx = bus.addr[RAM_AW+1:2];

  // Address bits ignored by the decode (aliasing and byte offset).
  assign w_unused_addr = ^{bus.addr[DATA_W-2:RAM_AW+2], bus.addr[1:0]};

  assign w_wr_ram   = bus.memwrite & ~w_is_io;
  assign w_wr_tx    = bus.memwrite & w_is_io & (w_sel == IO_TXDATA);
  assign w_wr_timer = bus.memwrite & w_is_io & (w_sel == IO_TIMER);
  assign w_wr_drop  = bus.memwrite & w_is_io & (w_sel == IO_DROP);

  // Rejected push: full and the head is not leaving this cycle.
  assign w_drop = w_wr_tx & w_full & ~bus.tx_ready;

  dmem_tx_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_wr_tx),
    .i_din   (bus.wdata[7:0]),
    .o_full  (w_full),
    .i_pop   (bus.tx_ready),
    .o_dout  (bus.tx_data),
    .o_valid (bus.tx_valid),
    .o_count (w_count)
  );

  // RAM contents survive reset, so no reset branch here.
  always_ff @(posedge clk) begin
    if (w_wr_ram) begin
      r_ram[w_ram_idx] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_wr_timer) begin
      r_timer <= bus.wdata;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // A clear wins over a rejected push arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_wr_drop) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != '1)) begin
      r_drop <= r_drop + 1'b1;
    end
  end

  always_comb begin
    w_status                                = '0;
    w_status[ST_FULL]                       = w_full;
    w_status[ST_EMPTY]                      = (w_count == '0);
    w_status[ST_COUNT_LSB +: FIFO_AW+1]     = w_count;
  end

  always_comb begin
    bus.rdata = '0;
    if (!w_is_io) begin
      bus.rdata = r_ram[w_ram_idx];
    end else begin
      case (w_sel)
        IO_TXDATA: bus.rdata = '0;
        IO_STATUS: bus.rdata = w_status;
        IO_TIMER:  bus.rdata = r_timer;
        IO_DROP:   bus.rdata = DATA_W'(r_drop);
        default:   bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  localparam logic [31:0] A_TX = 32'h8000_0000;
  localparam logic [31:0] A_ST = 32'h8000_0004;
  localparam logic [31:0] A_TM = 32'h8000_0008;
  localparam logic [31:0] A_DR = 32'h8000_000C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_resp_if #(.DATA_W(32)) bus ();

  dmem_resp #(
    .DATA_W  (32),
    .RAM_AW  (8),
    .FIFO_AW (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_ram   [256];
  bit          m_known [256];
  logic [7:0]  m_q     [$];
  logic [31:0] m_timer;
  int unsigned m_drop;

  function automatic void model_reset();
    m_q.delete();
    m_timer = 32'd0;
    m_drop  = 0;
  endfunction

  function automatic logic [31:0] model_status();
    int unsigned n;
    n = m_q.size();
    return 32'((n == 8 ? 1 : 0) + (n == 0 ? 2 : 0) + n * 16);
  endfunction

  function automatic bit model_known(input logic [31:0] a);
    return a[31] || m_known[a[9:2]];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!a[31]) return m_ram[a[9:2]];
    case (a[3:2])
      2'd0:    return 32'd0;
      2'd1:    return model_status();
      2'd2:    return m_timer;
      default: return 32'(m_drop);
    endcase
  endfunction

  function automatic void model_step(input logic [31:0] a, input logic [31:0] d,
                                     input logic we, input logic rdy);
    bit pop, full;
    pop  = rdy && (m_q.size() > 0);
    full = (m_q.size() == 8);
    if (pop) void'(m_q.pop_front());
    if (we && !a[31]) begin
      m_ram[a[9:2]]   = d;
      m_known[a[9:2]] = 1'b1;
    end
    if (we && a[31] && a[3:2] == 2'd0) begin
      if (!full || pop) m_q.push_back(d[7:0]);
      else if (m_drop < 65535) m_drop++;
    end
    if (we && a[31] && a[3:2] == 2'd3) m_drop = 0;
    if (we && a[31] && a[3:2] == 2'd2) m_timer = d;
    else m_timer = m_timer + 32'd1;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] d,
                       input logic we, input logic rdy);
    bus.addr     = a;
    bus.wdata    = d;
    bus.memwrite = we;
    bus.tx_ready = rdy;
    #1;
  endtask

  task automatic edge_step();
    model_step(bus.addr, bus.wdata, bus.memwrite, bus.tx_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(A_ST, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic push(input logic [7:0] b);
    apply(A_TX, {24'd0, b}, 1'b1, 1'b0);
    edge_step();
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    apply(a, 32'd0, 1'b0, 1'b0);
    check(name, bus.rdata, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_valid;
    logic        chk_txd;
    logic [7:0]  exp_txd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic [31:0] a, logic [31:0] d, logic we, logic rdy,
                              logic chk, logic [31:0] er, logic ev, logic ct, logic [7:0] et);
    vec_t v;
    v.addr = a; v.wdata = d; v.we = we; v.rdy = rdy; v.chk_rd = chk;
    v.exp_rd = er; v.exp_valid = ev; v.chk_txd = ct; v.exp_txd = et;
    return v;
  endfunction

  initial begin
    logic [31:0] a, d;
    logic        we, rdy;
    logic [1:0]  rg;
    int unsigned r;

    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.memwrite = 1'b0; bus.tx_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // reset state
    read_chk("reset status", A_ST, 32'h0000_0002);
    check("reset tx_valid", 32'(bus.tx_valid), 32'd0);
    check("reset tx_data", 32'(bus.tx_data), 32'd0);
    read_chk("reset drop", A_DR, 32'd0);
    read_chk("reset timer", A_TM, 32'd0);

    // table: RAM, alias, same-cycle read-old, FIFO order, STATUS writes ignored
    vt.push_back(mk(32'h10,  32'h1234_5678, 1, 0, 0, 0,            0, 0, 0));
    vt.push_back(mk(32'h10,  0,             0, 0, 1, 32'h1234_5678, 0, 0, 0));
    vt.push_back(mk(32'h410, 0,             0, 0, 1, 32'h1234_5678, 0, 0, 0));
    vt.push_back(mk(A_ST,    0,             0, 0, 1, 32'h2,         0, 0, 0));
    vt.push_back(mk(A_TX,    32'h41,        1, 0, 1, 32'h0,         0, 0, 0));
    vt.push_back(mk(A_TX,    32'h42,        1, 0, 0, 0,             1, 1, 8'h41));
    vt.push_back(mk(A_TX,    32'h43,        1, 0, 0, 0,             1, 1, 8'h41));
    vt.push_back(mk(A_ST,    0,             0, 0, 1, 32'h30,        1, 1, 8'h41));
    vt.push_back(mk(32'h13,  0,             0, 1, 1, 32'h1234_5678, 1, 1, 8'h41));
    vt.push_back(mk(A_ST,    0,             0, 1, 1, 32'h20,        1, 1, 8'h42));
    vt.push_back(mk(A_ST,    0,             0, 1, 1, 32'h10,        1, 1, 8'h43));
    vt.push_back(mk(A_ST,    0,             0, 0, 1, 32'h02,        0, 0, 0));
    vt.push_back(mk(A_ST,    32'hFFFF_FFFF, 1, 0, 1, 32'h02,        0, 0, 0));
    vt.push_back(mk(32'h10,  32'hDEAD_BEEF, 1, 0, 1, 32'h1234_5678, 0, 0, 0));
    vt.push_back(mk(32'h410, 0,             0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0));
    vt.push_back(mk(A_ST,    0,             0, 0, 1, 32'h02,        0, 0, 0));
    vt.push_back(mk(A_DR,    0,             0, 0, 1, 32'h0,         0, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].addr, vt[i].wdata, vt[i].we, vt[i].rdy);
      if (vt[i].chk_rd) check($sformatf("vec%0d rdata", i), bus.rdata, vt[i].exp_rd);
      check($sformatf("vec%0d tx_valid", i), 32'(bus.tx_valid), 32'(vt[i].exp_valid));
      if (vt[i].chk_txd) check($sformatf("vec%0d tx_data", i), 32'(bus.tx_data), 32'(vt[i].exp_txd));
      edge_step();
    end

    // overflow: 10 pushes into 8 entries
    do_reset();
    for (int i = 0; i < 10; i++) push(8'(8'hA0 + i));
    read_chk("ovf status", A_ST, 32'h0000_0081);
    read_chk("ovf drop", A_DR, 32'd2);
    for (int i = 0; i < 8; i++) begin
      apply(A_ST, 32'd0, 1'b0, 1'b1);
      check($sformatf("ovf valid%0d", i), 32'(bus.tx_valid), 32'd1);
      check($sformatf("ovf byte%0d", i), 32'(bus.tx_data), 32'(8'hA0 + i));
      edge_step();
    end
    read_chk("ovf drained status", A_ST, 32'h0000_0002);

    // full FIFO with simultaneous pop and push
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    read_chk("fullpop pre status", A_ST, 32'h0000_0081);
    apply(A_TX, 32'h5A, 1'b1, 1'b1);
    check("fullpop head", 32'(bus.tx_data), 32'h10);
    edge_step();
    read_chk("fullpop status", A_ST, 32'h0000_0081);
    read_chk("fullpop drop", A_DR, 32'd2);
    for (int i = 0; i < 8; i++) begin
      apply(A_ST, 32'd0, 1'b0, 1'b1);
      check($sformatf("fullpop byte%0d", i), 32'(bus.tx_data),
            (i == 7) ? 32'h5A : 32'(8'h11 + i));
      edge_step();
    end
    apply(A_DR, 32'h1234, 1'b1, 1'b0);
    edge_step();
    read_chk("drop cleared", A_DR, 32'd0);

    // timer load and wrap
    apply(A_TM, 32'hFFFF_FFFE, 1'b1, 1'b0);
    edge_step();
    read_chk("timer load", A_TM, 32'hFFFF_FFFE);
    edge_step();
    read_chk("timer +1", A_TM, 32'hFFFF_FFFF);
    edge_step();
    read_chk("timer wrap", A_TM, 32'h0000_0000);
    edge_step();

    // reset mid-drain
    for (int i = 0; i < 4; i++) push(8'(8'h61 + i));
    apply(A_ST, 32'd0, 1'b0, 1'b1);
    edge_step();
    apply(A_ST, 32'd0, 1'b0, 1'b0);
    check("pre-rst valid", 32'(bus.tx_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rst async valid", 32'(bus.tx_valid), 32'd0);
    check("rst async data", 32'(bus.tx_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    read_chk("post-rst status", A_ST, 32'h0000_0002);
    read_chk("post-rst drop", A_DR, 32'd0);
    read_chk("post-rst timer0", A_TM, 32'd0);
    edge_step();
    read_chk("post-rst timer1", A_TM, 32'd1);
    edge_step();

    // randomized against the reference model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 9);
      d = $urandom;
      if (r < 3) begin
        a  = $urandom & 32'h7FFF_FC3F;
        we = 1'($urandom_range(0, 1));
      end else begin
        rg = (r < 7) ? 2'd0 : 2'($urandom_range(1, 3));
        a  = 32'h8000_0000 | ($urandom & 32'h7FFF_FFF3) | {28'd0, rg, 2'd0};
        if (rg >= 2'd2) we = ($urandom_range(0, 7) == 0);
        else            we = 1'($urandom_range(0, 1));
      end
      rdy = ($urandom_range(0, 9) < 3);
      apply(a, d, we, rdy);
      if (model_known(a)) check($sformatf("rnd%0d rdata @%08h", n, a), bus.rdata, model_read(a));
      check($sformatf("rnd%0d tx_valid", n), 32'(bus.tx_valid), 32'(m_q.size() != 0));
      if (m_q.size() > 0) check($sformatf("rnd%0d tx_data", n), 32'(bus.tx_data), 32'(m_q[0]));
      edge_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-side memory responder for the single-cycle MIPS core; the target of the core's data accesses (address = ALU result, write data, memwrite strobe).
- Serves a word RAM and a small memory-mapped I/O window:
  - console TX byte FIFO, drained over a valid/ready stream;
  - free-running cycle timer;
  - dropped-byte counter.
- Reads are combinational, so the core's load completes in the same cycle. All state updates on the rising clock edge.

Parameters:
- DATA_W, 32, data/address word width.
- RAM_AW, 8, RAM word-address bits (2^RAM_AW words).
- FIFO_AW, 3, TX FIFO depth = 2^FIFO_AW entries of 8 bits.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- addr  in  DATA_W  byte address from core.
- wdata  in  DATA_W  store data from core.
- memwrite  in  1  store strobe; write occurs at the clk edge while high.
- rdata  out  DATA_W  combinational load data for addr.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  sink accepts head byte when tx_valid & tx_ready at the clk edge.

Behaviour:
- Reset: asynchronous on rst high.
  - FIFO pointers and count cleared: tx_valid=0, tx_data=0.
  - timer=0, drop=0.
  - RAM contents not reset.
- Decode:
  - addr[31]=0: RAM, word index addr[RAM_AW+1:2]. addr[1:0] ignored; upper bits ignored (aliasing).
  - addr[31]=1: I/O, selected by addr[3:2]; addr[30:4] ignored.
- RAM:
  - Read is combinational.
  - Write of the full word at the clk edge when memwrite=1. A read of the same address in the same cycle returns the old value.
- I/O 0x8000_0000 TXDATA:
  - Write pushes wdata[7:0].
  - Read returns 0.
- I/O 0x8000_0004 STATUS (read-only; writes ignored):
  - bit0 full, bit1 empty, bits[FIFO_AW+4:4] count (FIFO_AW+1 bits), other bits 0.
  - After reset reads 0x0000_0002.
- I/O 0x8000_0008 TIMER:
  - Increments by 1 every cycle; wraps 0xFFFF_FFFF->0.
  - Write loads wdata; the load overrides the increment that cycle, so the next cycle reads wdata, then wdata+1, and so on.
- I/O 0x8000_000C DROP:
  - Counts pushes rejected because the FIFO was full; 16-bit, saturates at 0xFFFF; read zero-extended.
  - Any write clears it to 0. A clear and a rejected push in the same cycle leave the value 0.
- FIFO:
  - tx_data=mem[rd_ptr], tx_valid=(count!=0), both direct from registers.
  - Pop when tx_valid & tx_ready.
  - Push when TXDATA write and (not full, or pop in the same cycle). A full FIFO with a simultaneous pop accepts the push; count is unchanged.
  - Empty FIFO with a push: tx_valid rises the next cycle; no same-cycle bypass.
  - Pointers wrap modulo 2^FIFO_AW.
  - Bytes leave in push order; none lost except counted drops.
- rst asserted mid-stream: FIFO contents discarded and tx_valid falls immediately (asynchronous). The sink must tolerate an abandoned byte.

Decomposition:
- Shared package (def.h style) holds:
  - IO_BASE=32'h8000_0000;
  - register offsets TXDATA=0, STATUS=1, TIMER=2, DROP=3 (word indices);
  - STATUS bit positions;
  - DROP_W=16.
- One sub-module: dmem_tx_fifo (parameter FIFO_AW; push/din/full, pop/dout/valid/count). Decode, RAM, timer and drop counter stay in dmem_resp.

Test Plan:
- RAM: write 0x1234_5678 to 0x0000_0010; read 0x10 -> 0x1234_5678. Read 0x0000_0410 (RAM_AW=8) -> same word (alias).
- FIFO order: tx_ready=0; push 0x41,0x42,0x43. STATUS -> 0x0000_0030. Raise tx_ready -> tx_data 0x41,0x42,0x43 on consecutive cycles. STATUS ends 0x0000_0002.
- Overflow: tx_ready=0; push 10 bytes -> STATUS=0x81, DROP=2, bytes 0..7 delivered.
- Full+pop: with FIFO full, tx_ready=1 and push 0x5A in the same cycle -> count stays 8, DROP unchanged, 0x5A delivered last.
- Timer: write 0xFFFF_FFFE -> subsequent reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Reset: assert rst mid-drain with 4 bytes queued -> tx_valid=0 at once. After release STATUS=0x2, TIMER counts from 0, DROP=0.
